fbuff_write_arbiter: RTL and testbench

- Round-robin arbiter sharing the single framebuffer Avalon-MM write master among NUM_PORTS writers: line fillers, host write-through, and future fill engines.
- Each writer sees an Avalon-MM write slave with waitrequest back-pressure.
- One registered output stage sustains one write per clock when the framebuffer is not stalling.
- Sits between the fill engines and the framebuffer memory's write port.

---
 rtl/fbuff_write_arbiter_if.sv | 30 +++
 rtl/fbuff_write_arbiter.sv | 127 ++++++++++++
 tb/tb_fbuff_write_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fbuff_write_arbiter_if.sv
// Bus bundle between the framebuffer write arbiter, its writers and the framebuffer write port.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface fbuff_write_arbiter_if #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 16
);
   logic [NUM_PORTS-1:0]        avs_write;
   logic [NUM_PORTS*ADDR_W-1:0] avs_address;
   logic [NUM_PORTS*32-1:0]     avs_writedata;
   logic [NUM_PORTS*4-1:0]      avs_byteenable;
   logic [NUM_PORTS-1:0]        avs_waitrequest;
   logic                        avm_fbuff_write;
   logic [ADDR_W-1:0]           avm_fbuff_address;
   logic [31:0]                 avm_fbuff_writedata;
   logic [3:0]                  avm_fbuff_byteenable;
   logic                        avm_fbuff_waitrequest;
   logic [2:0]                  grant_port;

   modport slave (
      input  avs_write, avs_address, avs_writedata, avs_byteenable, avm_fbuff_waitrequest,
      output avs_waitrequest, avm_fbuff_write, avm_fbuff_address, avm_fbuff_writedata,
             avm_fbuff_byteenable, grant_port
   );

   modport master (
      output avs_write, avs_address, avs_writedata, avs_byteenable, avm_fbuff_waitrequest,
      input  avs_waitrequest, avm_fbuff_write, avm_fbuff_address, avm_fbuff_writedata,
             avm_fbuff_byteenable, grant_port
   );
endinterface

// File: rtl/fbuff_write_arbiter.sv
// Round-robin arbiter multiplexing NUM_PORTS Avalon-MM write slaves onto one
// registered framebuffer write master; one accept per clock when not stalled.
module fbuff_write_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   fbuff_write_arbiter_if.slave bus
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [2:0]        rr_r;
   logic [2:0]        grant_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       data_r;
   logic [3:0]        be_r;

   logic [7:0]        req_s;
   logic [2:0]        winner_s;
   logic              winner_valid_s;
   logic              can_accept_s;
   logic              accept_s;

   logic [ADDR_W-1:0] port_addr_s [8];
   logic [31:0]       port_data_s [8];
   logic [3:0]        port_be_s   [8];

   function automatic logic [2:0] wrap_idx(input logic [2:0] base, input logic [3:0] off);
      logic [3:0] sum;
      sum = {1'b0, base} + off;
      return (sum >= 4'(NUM_PORTS)) ? 3'(sum - 4'(NUM_PORTS)) : sum[2:0];
   endfunction

   // Unpack the flat per-port buses into fixed 8-entry tables indexed by port number.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         port_addr_s[i] = {ADDR_W{1'b0}};
         port_data_s[i] = 32'd0;
         port_be_s[i]   = 4'd0;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         port_addr_s[i] = bus.avs_address[i*ADDR_W +: ADDR_W];
         port_data_s[i] = bus.avs_writedata[i*32 +: 32];
         port_be_s[i]   = bus.avs_byteenable[i*4 +: 4];
      end
   end

   // Round-robin search; scanning from the far end lets the port nearest rr_r win.
   always_comb begin
      req_s          = 8'(bus.avs_write);
      winner_s       = 3'd0;
      winner_valid_s = 1'b0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         winner_s       = req_s[wrap_idx(rr_r, 4'(k))] ? wrap_idx(rr_r, 4'(k)) : winner_s;
         winner_valid_s = winner_valid_s | req_s[wrap_idx(rr_r, 4'(k))];
      end
   end

   assign can_accept_s = (state_r == EMPTY) || !bus.avm_fbuff_waitrequest;
   assign accept_s     = can_accept_s && winner_valid_s;

   // Output-register occupancy state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state: a new accept keeps the register full, an unstalled drain empties it.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         EMPTY: begin
            if (accept_s) state_nxt_s = FULL;
            else          state_nxt_s = EMPTY;
         end
         FULL: begin
            if (accept_s)                        state_nxt_s = FULL;
            else if (!bus.avm_fbuff_waitrequest) state_nxt_s = EMPTY;
            else                                 state_nxt_s = FULL;
         end
         default: state_nxt_s = EMPTY;
      endcase
   end

   // Per-port stall: only the winning port is released, and nobody while in reset.
   always_comb begin
      bus.avs_waitrequest = {NUM_PORTS{1'b1}};
      for (int i = 0; i < NUM_PORTS; i++) begin
         bus.avs_waitrequest[i] = reset || !(accept_s && (winner_s == 3'(i)));
      end
   end

   // Output payload, grant index and rr pointer load together on every accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_r  <= {ADDR_W{1'b0}};
         data_r  <= 32'd0;
         be_r    <= 4'd0;
         grant_r <= 3'd0;
         rr_r    <= 3'd0;
      end else if (accept_s) begin
         addr_r  <= port_addr_s[winner_s];
         data_r  <= port_data_s[winner_s];
         be_r    <= port_be_s[winner_s];
         grant_r <= winner_s;
         rr_r    <= wrap_idx(winner_s, 4'd1);
      end else begin
         addr_r  <= addr_r;
         data_r  <= data_r;
         be_r    <= be_r;
         grant_r <= grant_r;
         rr_r    <= rr_r;
      end
   end

   assign bus.avm_fbuff_write      = (state_r == FULL);
   assign bus.avm_fbuff_address    = addr_r;
   assign bus.avm_fbuff_writedata  = data_r;
   assign bus.avm_fbuff_byteenable = be_r;
   assign bus.grant_port           = grant_r;
endmodule

// File: tb/tb_fbuff_write_arbiter.sv
// Directed bench for fbuff_write_arbiter: a vector table for arbitration/stall/drain
// plus hand sequences for single request, back-to-back writes and mid-stall reset.
module tb_fbuff_write_arbiter;
   localparam int NP = 4;
   localparam int AW = 16;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fbuff_write_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

   fbuff_write_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0] wr;
      logic       fbw;
      logic [3:0] exp_wait;
      logic       exp_write;
      logic [2:0] exp_grant;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Port i carries address 0x1000+i, data 0xD0000000+i, byteenable i.
   task automatic set_defaults();
      for (int i = 0; i < NP; i++) begin
         bus.avs_address[i*AW +: AW]   = 16'h1000 + 16'(i);
         bus.avs_writedata[i*32 +: 32] = 32'hD000_0000 + 32'(i);
         bus.avs_byteenable[i*4 +: 4]  = 4'(i);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.avs_write = 4'b1111;
      bus.avm_fbuff_waitrequest = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_waitreq", 32'(bus.avs_waitrequest), 32'h0000_000F);
      check("rst_write",   32'(bus.avm_fbuff_write), 32'd0);
      check("rst_grant",   32'(bus.grant_port), 32'd0);
      check("rst_addr",    32'(bus.avm_fbuff_address), 32'd0);
      bus.avs_write = 4'b0000;
      reset = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{4'b1111, 1'b0, 4'b1110, 1'b1, 3'd0};
      vecs[1]  = '{4'b1111, 1'b0, 4'b1101, 1'b1, 3'd1};
      vecs[2]  = '{4'b1111, 1'b0, 4'b1011, 1'b1, 3'd2};
      vecs[3]  = '{4'b1111, 1'b0, 4'b0111, 1'b1, 3'd3};
      vecs[4]  = '{4'b1111, 1'b0, 4'b1110, 1'b1, 3'd0};
      vecs[5]  = '{4'b0000, 1'b0, 4'b1111, 1'b0, 3'd0};
      vecs[6]  = '{4'b0000, 1'b0, 4'b1111, 1'b0, 3'd0};
      vecs[7]  = '{4'b1001, 1'b0, 4'b0111, 1'b1, 3'd3};
      vecs[8]  = '{4'b1001, 1'b0, 4'b1110, 1'b1, 3'd0};
      vecs[9]  = '{4'b1001, 1'b1, 4'b1111, 1'b1, 3'd0};
      vecs[10] = '{4'b0010, 1'b1, 4'b1111, 1'b1, 3'd0};
      vecs[11] = '{4'b0010, 1'b0, 4'b1101, 1'b1, 3'd1};
      vecs[12] = '{4'b0000, 1'b1, 4'b1111, 1'b1, 3'd1};
      vecs[13] = '{4'b0000, 1'b0, 4'b1111, 1'b0, 3'd1};
      vecs[14] = '{4'b0100, 1'b1, 4'b1011, 1'b1, 3'd2};

      set_defaults();
      do_reset();

      // Single request from port 2 with the framebuffer idle.
      bus.avs_address[2*AW +: AW]   = 16'h1234;
      bus.avs_writedata[2*32 +: 32] = 32'hDEAD_BEEF;
      bus.avs_byteenable[2*4 +: 4]  = 4'b1111;
      bus.avs_write = 4'b0100;
      @(negedge clk);
      check("single_waitreq", 32'(bus.avs_waitrequest), 32'h0000_000B);
      @(posedge clk); #1;
      bus.avs_write = 4'b0000;
      check("single_write", 32'(bus.avm_fbuff_write), 32'd1);
      check("single_addr",  32'(bus.avm_fbuff_address), 32'h0000_1234);
      check("single_data",  bus.avm_fbuff_writedata, 32'hDEAD_BEEF);
      check("single_be",    32'(bus.avm_fbuff_byteenable), 32'h0000_000F);
      check("single_grant", 32'(bus.grant_port), 32'd2);
      @(posedge clk); #1;
      check("single_drain", 32'(bus.avm_fbuff_write), 32'd0);
      set_defaults();

      // Port 0 streams eight writes to addresses 0..7 back to back.
      for (int k = 0; k < 8; k++) begin
         bus.avs_write = 4'b0001;
         bus.avs_address[0 +: AW] = 16'(k);
         @(negedge clk);
         check("b2b_waitreq0", 32'(bus.avs_waitrequest[0]), 32'd0);
         @(posedge clk); #1;
         check("b2b_write", 32'(bus.avm_fbuff_write), 32'd1);
         check("b2b_addr",  32'(bus.avm_fbuff_address), 32'(k));
      end
      bus.avs_write = 4'b0000;
      @(posedge clk); #1;
      check("b2b_drain", 32'(bus.avm_fbuff_write), 32'd0);
      set_defaults();

      // Reset while the output register is full and stalled.
      bus.avm_fbuff_waitrequest = 1'b1;
      bus.avs_write = 4'b0010;
      @(posedge clk); #1;
      bus.avs_write = 4'b0000;
      check("stall_full", 32'(bus.avm_fbuff_write), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("midrst_write",   32'(bus.avm_fbuff_write), 32'd0);
      check("midrst_waitreq", 32'(bus.avs_waitrequest), 32'h0000_000F);
      check("midrst_grant",   32'(bus.grant_port), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      bus.avm_fbuff_waitrequest = 1'b0;
      bus.avs_write = 4'b0010;
      @(negedge clk);
      check("postrst_waitreq", 32'(bus.avs_waitrequest), 32'h0000_000D);
      @(posedge clk); #1;
      bus.avs_write = 4'b0000;
      check("postrst_write", 32'(bus.avm_fbuff_write), 32'd1);
      check("postrst_grant", 32'(bus.grant_port), 32'd1);
      check("postrst_addr",  32'(bus.avm_fbuff_address), 32'h0000_1001);

      // Table: round-robin, pointer hold across idle, stall hold and drain.
      do_reset();
      for (int v = 0; v < 15; v++) begin
         bus.avs_write = vecs[v].wr;
         bus.avm_fbuff_waitrequest = vecs[v].fbw;
         @(negedge clk);
         check($sformatf("vec%0d_waitreq", v), 32'(bus.avs_waitrequest), 32'(vecs[v].exp_wait));
         @(posedge clk); #1;
         check($sformatf("vec%0d_write", v), 32'(bus.avm_fbuff_write), 32'(vecs[v].exp_write));
         check($sformatf("vec%0d_grant", v), 32'(bus.grant_port), 32'(vecs[v].exp_grant));
         check($sformatf("vec%0d_addr", v), 32'(bus.avm_fbuff_address),
               32'h0000_1000 + 32'(vecs[v].exp_grant));
         check($sformatf("vec%0d_data", v), bus.avm_fbuff_writedata,
               32'hD000_0000 + 32'(vecs[v].exp_grant));
         check($sformatf("vec%0d_be", v), 32'(bus.avm_fbuff_byteenable), 32'(vecs[v].exp_grant));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
